final_cpa_pipe: RTL and testbench

Two-stage pipelined carry-propagate adder that collapses the final sum and carry rows leaving the Wallace compressor tree into the 32-bit product of the radix-4 Booth 16x16 multiplier. It sits directly downstream of the last 4:2 compressor level. It splits the add into a low-half and a high-half stage, with the low-half carry registered between them. Valid/ready handshakes on both sides allow back-pressure without losing or duplicating operands.

---
 rtl/mult_pkg.sv | 13 +
 rtl/cpa_half_adder.sv | 31 +++
 rtl/final_cpa_pipe.sv | 116 +++++++++++
 tb/tb_final_cpa_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Constants shared by the radix-4 Booth 16x16 multiplier datapath: the Booth
// encoder, the Wallace compressor tree and the final carry-propagate adder.
//   PRODUCT_W : width of the product and of the sum/carry rows
//   HALF_W    : width of each half of the split carry-propagate add
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int PRODUCT_W = 32;
    localparam int HALF_W    = PRODUCT_W / 2;

endpackage : mult_pkg

// File: rtl/cpa_half_adder.sv
// -----------------------------------------------------------------------------
// cpa_half_adder
// Combinational HW-bit ripple/carry-propagate adder with carry-in, used for
// one half of the final product add.
//   a, b : HW-bit addends
//   cin  : carry into bit 0
//   sum  : low HW bits of a + b + cin
//   cout : carry out of bit HW-1
// -----------------------------------------------------------------------------
module cpa_half_adder #(
    parameter int HW = 16
) (
    input  logic [HW-1:0] a,
    input  logic [HW-1:0] b,
    input  logic          cin,
    output logic [HW-1:0] sum,
    output logic          cout
);

    logic [HW:0] total_s;

    // One extra bit of headroom captures the carry out of the half.
    always_comb begin
        total_s = {(HW+1){1'b0}};
        total_s = {1'b0, a} + {1'b0, b} + {{HW{1'b0}}, cin};
    end

    assign sum  = total_s[HW-1:0];
    assign cout = total_s[HW];

endmodule : cpa_half_adder

// File: rtl/final_cpa_pipe.sv
// -----------------------------------------------------------------------------
// final_cpa_pipe
// Two-stage pipelined carry-propagate adder that collapses the sum and carry
// rows from the last compressor level into the final product. Stage 1 adds
// the low halves and registers the carry; stage 2 adds the high halves with
// that carry. Valid/ready on both sides; the carry out of the top bit is
// dropped, so the result is (row_s + row_c) mod 2^WIDTH.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   in_valid/in_ready  : upstream handshake (in_ready is combinational)
//   row_s, row_c       : sum and pre-aligned carry rows
//   out_valid/out_ready: downstream handshake (out_valid is registered)
//   product            : registered result
// -----------------------------------------------------------------------------
module final_cpa_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH = PRODUCT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_s,
    input  logic [WIDTH-1:0] row_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    localparam int HW = WIDTH / 2;

    // Stage 1 registers
    logic          s1_valid_r;
    logic [HW-1:0] s1_lo_r;
    logic          s1_cy_r;
    logic [HW-1:0] s1_hi_s_r;
    logic [HW-1:0] s1_hi_c_r;

    // Output stage registers
    logic             out_valid_r;
    logic [WIDTH-1:0] product_r;

    // Handshake and adder nets
    logic          s2_free_s;
    logic          s1_free_s;
    logic          in_xfer_s;
    logic          s1_move_s;
    logic [HW-1:0] lo_sum_s;
    logic          lo_cy_s;
    logic [HW-1:0] hi_sum_s;
    logic          hi_cout_unused_s;

    // A stage is free when empty or when its occupant leaves this cycle.
    assign s2_free_s = !out_valid_r || out_ready;
    assign s1_free_s = !s1_valid_r || s2_free_s;
    assign in_ready  = s1_free_s;
    assign in_xfer_s = in_valid && s1_free_s;
    assign s1_move_s = s1_valid_r && s2_free_s;

    cpa_half_adder #(.HW(HW)) u_lo_add (
        .a    (row_s[HW-1:0]),
        .b    (row_c[HW-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_s),
        .cout (lo_cy_s)
    );

    // The carry out of the top half is the mod-2^WIDTH wrap and is dropped.
    cpa_half_adder #(.HW(HW)) u_hi_add (
        .a    (s1_hi_s_r),
        .b    (s1_hi_c_r),
        .cin  (s1_cy_r),
        .sum  (hi_sum_s),
        .cout (hi_cout_unused_s)
    );

    // Stage 1: low-half sum, its carry, and the untouched high halves.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_lo_r    <= {HW{1'b0}};
            s1_cy_r    <= 1'b0;
            s1_hi_s_r  <= {HW{1'b0}};
            s1_hi_c_r  <= {HW{1'b0}};
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_lo_r    <= lo_sum_s;
            s1_cy_r    <= lo_cy_s;
            s1_hi_s_r  <= row_s[WIDTH-1:HW];
            s1_hi_c_r  <= row_c[WIDTH-1:HW];
        end else if (s1_move_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Output stage: assemble the product; hold it while back-pressured.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid_r <= 1'b0;
            product_r   <= {WIDTH{1'b0}};
        end else if (s1_move_s) begin
            out_valid_r <= 1'b1;
            product_r   <= {hi_sum_s, s1_lo_r};
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign product   = product_r;

endmodule : final_cpa_pipe

// File: tb/tb_final_cpa_pipe.sv
module tb_final_cpa_pipe;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] row_s;
    logic [31:0] row_c;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int unsigned total_checks;
    int unsigned failed_checks;
    int unsigned popped;
    logic        acc;
    logic        ov_seen;
    logic [31:0] exp_q[$];

    final_cpa_pipe #(.WIDTH(32)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp)
        else begin
            failed_checks++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: at the negedge record handshakes (scoreboard pop/push), then
    // advance past the next rising edge so inputs can be changed safely.
    task automatic cycle();
        logic [31:0] e;
        @(negedge sys_clk);
        ov_seen = out_valid;
        acc     = in_valid && in_ready;
        if (out_valid && out_ready) begin
            popped++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", product, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_product", product, e);
            end
        end
        if (acc) exp_q.push_back(row_s + row_c);
        @(posedge sys_clk);
        #1;
    endtask

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input logic [31:0] s, input logic [31:0] c);
        int n;
        row_s    = s;
        row_c    = c;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cycle();
            n++;
        end
        if (!acc) check("send_accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    // Single operand: out_valid low one cycle after acceptance, high the next.
    task automatic latency_test(input string tag, input logic [31:0] s, input logic [31:0] c);
        logic [31:0] e;
        e = s + c;
        out_ready = 1'b1;
        send(s, c);
        check({tag, "_ov_lat1"}, {31'd0, out_valid}, 32'd0);
        cycle();
        check({tag, "_ov_lat2"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_product"}, product, e);
        cycle();
    endtask

    initial begin
        int unsigned p0;
        int unsigned stalls;
        int unsigned gaps;
        int n;
        total_checks  = 0;
        failed_checks = 0;
        popped        = 0;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        row_s     = 32'd0;
        row_c     = 32'd0;

        // Reset and idle
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("idle_in_ready", {31'd0, in_ready}, 32'd1);
            check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            check("idle_product", product, 32'd0);
        end

        // Carry across the half boundary, then wrap-around cases
        latency_test("half_carry", 32'h0000_FFFF, 32'h0000_0001);
        latency_test("wrap_ones", 32'hFFFF_FFFF, 32'h0000_0001);
        latency_test("wrap_msb", 32'h8000_0000, 32'h8000_0000);
        latency_test("mixed", 32'h1234_8000, 32'h0FED_8000);

        // Back-to-back streaming of random pairs
        out_ready = 1'b1;
        p0 = popped;
        stalls = 0;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            row_s    = $urandom;
            row_c    = $urandom;
            in_valid = 1'b1;
            cycle();
            if (!acc) stalls++;
            if (i >= 2 && !ov_seen) gaps++;
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        check("stream_stalls", stalls, 32'd0);
        check("stream_gaps", gaps, 32'd0);
        check("stream_count", popped - p0, 32'd100);
        check("stream_queue_empty", exp_q.size(), 32'd0);

        // Back-pressure with three operands
        out_ready = 1'b0;
        p0 = popped;
        row_s = 32'h0000_0011; row_c = 32'h0000_0022; in_valid = 1'b1;
        cycle();
        check("bp_acc1", {31'd0, acc}, 32'd1);
        row_s = 32'hAAAA_0000; row_c = 32'h5555_FFFF;
        cycle();
        check("bp_acc2", {31'd0, acc}, 32'd1);
        row_s = 32'h7FFF_FFFF; row_c = 32'h0000_0003;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_product_held", product, 32'h0000_0033);
            cycle();
            check("bp_no_accept", {31'd0, acc}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", {31'd0, in_ready}, 32'd1);
        send(32'h7FFF_FFFF, 32'h0000_0003);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        check("bp_drain_count", popped - p0, 32'd3);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset with two operands in flight
        out_ready = 1'b0;
        row_s = 32'h0101_0101; row_c = 32'h0202_0202; in_valid = 1'b1;
        cycle();
        row_s = 32'h0303_0303;
        cycle();
        in_valid = 1'b0;
        check("rst_pre_out_valid", {31'd0, out_valid}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        cycle();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        latency_test("post_rst", 32'hDEAD_BEEF, 32'h2152_4111);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule : tb_final_cpa_pipe
